// File: rtl/sd_pkg.sv
// Shared definitions for the SD command sender slice: FSM states, frame
// geometry, CRC7 polynomial, common command indices and the CRC7 step.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INIT      = 2'd1,
    SEND      = 2'd2,
    WAIT_RESP = 2'd3
  } sd_state_e;

  localparam int         SD_FRAME_W = 48;
  localparam logic [6:0] CRC7_POLY  = 7'h09;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;

  // One serial CRC7 step: feedback is the incoming bit xor the register MSB.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_sender_if.sv
// Control-side handshake between the test sequencer and sd_cmd_sender.
// SD_CMD_RESP_CAPTURE_EN adds the captured 48-bit response and its strobe.
interface sd_cmd_sender_if;

  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic        timeout;

`ifdef SD_CMD_RESP_CAPTURE_EN
  logic [47:0] resp_data;
  logic        resp_valid;

  modport master (output start, cmd_index, cmd_arg,
                  input  busy, done, timeout, resp_data, resp_valid);
  modport slave  (input  start, cmd_index, cmd_arg,
                  output busy, done, timeout, resp_data, resp_valid);
`else
  modport master (output start, cmd_index, cmd_arg,
                  input  busy, done, timeout);
  modport slave  (input  start, cmd_index, cmd_arg,
                  output busy, done, timeout);
`endif

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0). Shared by the command sender and
// future data/response checkers.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  // Clear wins over enable so a new frame always starts from zero.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_cmd_sender.sv
// Host-side SD command initiator: slow SD clock generation, power-up init
// clocks, 48-bit command frame on CMD, then wait for the response start bit.
// SD_CMD_RESP_CAPTURE_EN: also capture the full 48-bit response before done.
module sd_cmd_sender
  import sd_pkg::*;
#(
  parameter int CLK_HALF  = 100,
  parameter int INIT_CLKS = 80,
  parameter int NCR_MAX   = 64
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  sd_cmd_sender_if.slave   ctrl,
  output logic             sd_clk,
  output logic             sd_cmd_out,
  output logic             sd_cmd_oe,
  input  logic             sd_cmd_in
);

  localparam int DIV_W  = $clog2(CLK_HALF + 1);
  localparam int INIT_W = $clog2(INIT_CLKS + 1);
  localparam int NCR_W  = $clog2(NCR_MAX + 1);

  sd_state_e         state;
  logic [DIV_W-1:0]  div_cnt;
  logic              wrap;
  logic              fall_ev;
  logic              rise_ev;
  logic [INIT_W-1:0] init_cnt;
  logic              init_done;
  logic [5:0]        bit_cnt;
  logic [39:0]       shreg;
  logic [NCR_W-1:0]  ncr_cnt;
  logic [6:0]        crc;
  logic              crc_en;
  logic              accept;
  logic              done_q;
  logic              timeout_q;

`ifdef SD_CMD_RESP_CAPTURE_EN
  logic              capturing;
  logic [5:0]        resp_cnt;
  logic [46:0]       resp_shift;
  logic [47:0]       resp_data_q;
  logic              resp_valid_q;

  assign ctrl.resp_data  = resp_data_q;
  assign ctrl.resp_valid = resp_valid_q;
`endif

  assign accept       = (state == IDLE) && ctrl.start;
  assign ctrl.busy    = (state != IDLE) || ctrl.start;
  assign ctrl.done    = done_q;
  assign ctrl.timeout = timeout_q;

  assign wrap    = (state != IDLE) && (div_cnt == DIV_W'(CLK_HALF - 1));
  assign fall_ev = wrap && sd_clk;
  assign rise_ev = wrap && !sd_clk;

  // CRC covers only the first 40 frame bits, updated as each is driven.
  assign crc_en = (state == SEND) && fall_ev && (bit_cnt < 6'd40);

  sd_crc7 u_crc7 (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (crc_en),
    .bit_in   (shreg[39]),
    .crc      (crc)
  );

  // Clock divider: runs only while a command is in flight, idles high.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sd_clk  <= 1'b1;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      sd_clk  <= 1'b1;
    end else if (wrap) begin
      div_cnt <= '0;
      sd_clk  <= ~sd_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Command sequencing: CMD moves only on fall events, responses are sampled on rise events.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      init_done  <= 1'b0;
      init_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ncr_cnt    <= '0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef SD_CMD_RESP_CAPTURE_EN
      capturing    <= 1'b0;
      resp_cnt     <= '0;
      resp_shift   <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SD_CMD_RESP_CAPTURE_EN
      resp_valid_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ctrl.start) begin
            shreg      <= {2'b01, ctrl.cmd_index, ctrl.cmd_arg};
            bit_cnt    <= '0;
            init_cnt   <= '0;
            ncr_cnt    <= '0;
            sd_cmd_oe  <= 1'b1;
            sd_cmd_out <= 1'b1;
`ifdef SD_CMD_RESP_CAPTURE_EN
            capturing  <= 1'b0;
            resp_cnt   <= '0;
`endif
            state      <= init_done ? SEND : INIT;
          end
        end
        INIT: begin
          if (rise_ev) begin
            if (init_cnt == INIT_W'(INIT_CLKS - 1)) begin
              init_done <= 1'b1;
              state     <= SEND;
            end else begin
              init_cnt <= init_cnt + INIT_W'(1);
            end
          end
        end
        SEND: begin
          if (fall_ev) begin
            if (bit_cnt == 6'(SD_FRAME_W)) begin
              sd_cmd_oe  <= 1'b0;
              sd_cmd_out <= 1'b1;
              state      <= WAIT_RESP;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd40) begin
                sd_cmd_out <= crc[6];
                shreg      <= {crc[5:0], 1'b1, 33'd0};
              end else begin
                sd_cmd_out <= shreg[39];
                shreg      <= {shreg[38:0], 1'b0};
              end
            end
          end
        end
        WAIT_RESP: begin
`ifdef SD_CMD_RESP_CAPTURE_EN
          if (rise_ev) begin
            if (capturing) begin
              resp_shift <= {resp_shift[45:0], sd_cmd_in};
              if (resp_cnt == 6'd46) begin
                resp_data_q  <= {resp_shift, sd_cmd_in};
                resp_valid_q <= 1'b1;
                done_q       <= 1'b1;
                state        <= IDLE;
              end else begin
                resp_cnt <= resp_cnt + 6'd1;
              end
            end else if (!sd_cmd_in) begin
              capturing  <= 1'b1;
              resp_shift <= '0;
              resp_cnt   <= '0;
            end else if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
              timeout_q <= 1'b1;
              state     <= IDLE;
            end else begin
              ncr_cnt <= ncr_cnt + NCR_W'(1);
            end
          end
`else
          if (rise_ev) begin
            if (!sd_cmd_in) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
              timeout_q <= 1'b1;
              state     <= IDLE;
            end else begin
              ncr_cnt <= ncr_cnt + NCR_W'(1);
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Scoreboard bench for sd_cmd_sender: stimulus pushes expected frames and
// outcomes, a monitor decodes the CMD line and end pulses and compares.
// SD_CMD_RESP_CAPTURE_EN also checks the captured response.
module tb_sd_cmd_sender;
  import sd_pkg::*;

  localparam int CLK_HALF  = 4;
  localparam int INIT_CLKS = 80;
  localparam int NCR_MAX   = 64;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  logic sd_clk;
  logic sd_cmd_out;
  logic sd_cmd_oe;
  logic sd_cmd_in = 1'b1;

  sd_cmd_sender_if ctrl ();

  sd_cmd_sender #(
    .CLK_HALF  (CLK_HALF),
    .INIT_CLKS (INIT_CLKS),
    .NCR_MAX   (NCR_MAX)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .ctrl       (ctrl),
    .sd_clk     (sd_clk),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .sd_cmd_in  (sd_cmd_in)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          init_clks;
    logic [47:0] frame;
  } frame_exp_t;

  typedef struct {
    bit          done;
    int          rises;
    logic [47:0] resp;
  } outcome_exp_t;

  frame_exp_t   exp_frames[$];
  outcome_exp_t exp_outcomes[$];

  int total = 0;
  int bad   = 0;

  int          plan_rise = 0;
  logic [47:0] plan_resp = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference CRC7 by polynomial long division of msg * x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc_ref(head), 1'b1};
  endfunction

  // Value the modelled card presents for the n-th rise after the host releases CMD.
  function automatic logic resp_bit(input int n);
    if (plan_rise == 0 || n < plan_rise) return 1'b1;
    if (n == plan_rise) return 1'b0;
`ifdef SD_CMD_RESP_CAPTURE_EN
    if (n <= plan_rise + 47) return plan_resp[47 - (n - plan_rise)];
`endif
    return 1'b1;
  endfunction

  // Card model: drives one response bit per sd_clk fall once the host lets go of CMD.
  initial begin
    forever begin
      @(negedge sd_cmd_oe);
      if (reset_n) begin
        for (int n = 1; n <= NCR_MAX + 50; n++) begin
          sd_cmd_in = resp_bit(n);
          @(posedge sd_clk or negedge reset_n);
          #1;
          if (!reset_n || !ctrl.busy) break;
          @(negedge sd_clk or negedge reset_n);
          if (!reset_n) break;
        end
      end
      sd_cmd_in = 1'b1;
    end
  end

  // Monitor state.
  logic        prev_clk = 1'b1;
  logic        prev_cmd = 1'b1;
  bit          collecting = 0;
  int          bit_n = 0;
  logic [47:0] cap = '0;
  int          init_seen = 0;
  bit          waiting = 0;
  int          wait_rises = 0;
  int          cyc = 0;
  int          last_rise = 0;
  bit          rise_valid = 0;

  // Monitor: decode frames on sd_clk rises, count wait rises, score end pulses.
  always @(negedge CLOCK_50) begin
    frame_exp_t   fe;
    outcome_exp_t oe;
    logic         rise;
    logic         fall;
    cyc++;
    if (!reset_n) begin
      collecting = 0;
      init_seen  = 0;
      waiting    = 0;
      wait_rises = 0;
      rise_valid = 0;
    end else begin
      rise = sd_clk && !prev_clk;
      fall = !sd_clk && prev_clk;
      if (sd_cmd_out !== prev_cmd) checkOutput("cmd_on_fall", fall, 1);
      if (rise) begin
        if (rise_valid) checkOutput("sdclk_period", cyc - last_rise, 2 * CLK_HALF);
        rise_valid = 1;
        last_rise  = cyc;
        if (sd_cmd_oe) begin
          if (collecting) begin
            cap = {cap[46:0], sd_cmd_out};
            bit_n++;
            if (bit_n == 48) begin
              collecting = 0;
              if (exp_frames.size() == 0) begin
                checkOutput("frame_unexpected", 1, 0);
              end else begin
                fe = exp_frames.pop_front();
                checkOutput("init_clks", init_seen, fe.init_clks);
                checkOutput("frame", cap, fe.frame);
              end
              init_seen  = 0;
              waiting    = 1;
              wait_rises = 0;
            end
          end else if (sd_cmd_out == 1'b0) begin
            collecting = 1;
            cap        = '0;
            bit_n      = 1;
          end else begin
            init_seen++;
          end
        end else if (waiting) begin
          wait_rises++;
        end
      end
      if (ctrl.done || ctrl.timeout) begin
        checkOutput("done_and_timeout", ctrl.done && ctrl.timeout, 0);
        checkOutput("busy_at_end", ctrl.busy, 0);
        if (exp_outcomes.size() == 0) begin
          checkOutput("outcome_unexpected", 1, 0);
        end else begin
          oe = exp_outcomes.pop_front();
          checkOutput("done", ctrl.done, oe.done);
          checkOutput("timeout", ctrl.timeout, !oe.done);
          checkOutput("resp_rises", wait_rises, oe.rises);
`ifdef SD_CMD_RESP_CAPTURE_EN
          checkOutput("resp_valid", ctrl.resp_valid, oe.done);
          if (oe.done) checkOutput("resp_data", ctrl.resp_data, oe.resp);
`endif
        end
        waiting = 0;
      end
      if (!ctrl.busy) rise_valid = 0;
    end
    prev_clk = sd_clk;
    prev_cmd = sd_cmd_out;
  end

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input int rr,
                               input logic [47:0] resp, input int exp_init, input logic [47:0] exp_frame);
    frame_exp_t   fe;
    outcome_exp_t oe;
    plan_rise = rr;
    plan_resp = resp;
    fe.init_clks = exp_init;
    fe.frame     = exp_frame;
    exp_frames.push_back(fe);
    oe.done = (rr != 0);
`ifdef SD_CMD_RESP_CAPTURE_EN
    oe.rises = (rr != 0) ? rr + 47 : NCR_MAX;
`else
    oe.rises = (rr != 0) ? rr : NCR_MAX;
`endif
    oe.resp = resp;
    exp_outcomes.push_back(oe);
    @(negedge CLOCK_50);
    ctrl.cmd_index = idx;
    ctrl.cmd_arg   = arg;
    ctrl.start     = 1'b1;
    #1 checkOutput("busy_accept", ctrl.busy, 1);
    @(negedge CLOCK_50);
    ctrl.start     = 1'b0;
    ctrl.cmd_index = 6'($urandom);
    ctrl.cmd_arg   = $urandom;
    #1 checkOutput("busy_held", ctrl.busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLOCK_50);
      #2;
      if (exp_outcomes.size() == 0 && exp_frames.size() == 0 && !ctrl.busy) return;
    end
    checkOutput("completion_timeout", 1, 0);
    exp_frames.delete();
    exp_outcomes.delete();
  endtask

  task automatic wait_falls(input int n);
    int   seen;
    logic prev;
    seen = 0;
    prev = sd_clk;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLOCK_50);
      if (prev && !sd_clk) seen++;
      prev = sd_clk;
      if (seen == n) return;
    end
    checkOutput("fall_wait_timeout", 1, 0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_sd_clk"}, sd_clk, 1);
    checkOutput({tag, "_cmd_out"}, sd_cmd_out, 1);
    checkOutput({tag, "_cmd_oe"}, sd_cmd_oe, 0);
    checkOutput({tag, "_busy"}, ctrl.busy, 0);
    checkOutput({tag, "_done"}, ctrl.done, 0);
    checkOutput({tag, "_timeout"}, ctrl.timeout, 0);
`ifdef SD_CMD_RESP_CAPTURE_EN
    checkOutput({tag, "_resp_data"}, ctrl.resp_data, 0);
    checkOutput({tag, "_resp_valid"}, ctrl.resp_valid, 0);
`endif
  endtask

  initial begin
    logic [5:0]  idx;
    logic [31:0] arg;
    int          rr;
    logic [47:0] resp;
    ctrl.start     = 1'b0;
    ctrl.cmd_index = '0;
    ctrl.cmd_arg   = '0;
    reset_n        = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    $display("[TB] CMD0 with init clocks");
    applyStimulus(CMD0, 32'h0, 2, {2'b00, 46'h1234_5678_9AB}, INIT_CLKS, 48'h40_0000_0000_95);
    wait_idle();

    $display("[TB] CMD8 without init, response start on rise 5");
    applyStimulus(CMD8, 32'h0000_01AA, 5, 48'h08_0000_01AA_13, 0, 48'h48_0000_01AA_87);
    wait_idle();

    $display("[TB] CMD17 with no response");
    applyStimulus(CMD17, 32'h0, 0, '0, 0, 48'h51_0000_0000_55);
    wait_idle();

    $display("[TB] randomized commands");
    for (int k = 0; k < 8; k++) begin
      idx  = 6'($urandom_range(0, 63));
      arg  = $urandom;
      rr   = (k % 4 == 3) ? 0 : int'($urandom_range(1, NCR_MAX));
      resp = {2'b00, 14'($urandom), $urandom};
      applyStimulus(idx, arg, rr, resp, 0, frame_ref(idx, arg));
      wait_idle();
    end

    $display("[TB] start pulsed mid-SEND is ignored");
    applyStimulus(6'd55, 32'hDEAD_BEEF, 3, {2'b00, 46'h2AAA_5555_0F0}, 0, frame_ref(6'd55, 32'hDEAD_BEEF));
    wait_falls(10);
    @(negedge CLOCK_50);
    ctrl.cmd_index = 6'd17;
    ctrl.cmd_arg   = 32'h0BAD_F00D;
    ctrl.start     = 1'b1;
    @(negedge CLOCK_50);
    ctrl.start     = 1'b0;
    wait_idle();

    $display("[TB] reset during SEND bit 20");
    applyStimulus(CMD8, 32'h0000_01AA, 5, 48'h08_0000_01AA_13, 0, 48'h48_0000_01AA_87);
    wait_falls(21);
    repeat (2) @(negedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1 check_reset_values("midreset");
    exp_frames.delete();
    exp_outcomes.delete();
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    applyStimulus(CMD0, 32'h0, 4, {2'b00, 46'h0F0F_0F0F_0F0}, INIT_CLKS, 48'h40_0000_0000_95);
    wait_idle();

    repeat (5) @(negedge CLOCK_50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Last-resort guard in case a wait above never returns.
  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
